ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Sequences and shares the single-port 16x4 ram (async read, sync write) between two requesters.
//  Requesters: requester 0 is the button/edit path; requester 1 is the display-scan path.
//  After reset it clears the whole array, then grants one access per cycle, round-robin.
//  Sits between the requesters and the ram instance and owns the ram's enable, ab and dbi pins.
// PARAMETERS
//  AW      4     ram address width (depth = 2**AW)
//  DW      4     ram data width
//  CLR_VAL 4'h0  value written to every word during the post-reset clear sweep
// PORTS
//  clk       in   1   single clock, all state updates on posedge
//  rst_n     in   1   synchronous reset, active-low
//  req0/req1 in   1   access request; hold high with we/addr/wdata stable until the matching ack
//  we0/we1   in   1   1 = write wdata to addr; 0 = read addr
//  addr0/1   in   AW  word address
//  wdata0/1  in   DW  write data
//  ack0/ack1 out  1   high for exactly one cycle: the cycle in which the access is issued to the ram
//  rdata0/1  out  DW  registered read data; updated at the posedge ending a read ack, else held
//  ready     out  1   0 during reset and the clear sweep, 1 afterwards
//  ram_en    out  1   to ram enable (write strobe)
//  ram_ab    out  AW  to ram ab
//  ram_dbi   out  DW  to ram dbi
//  ram_dbo   in   DW  from ram dbo (combinational read of ram_ab)
// BEHAVIOUR
//  - Reset (rst_n low at a posedge): state<=CLEAR, clr_cnt<=0, owner<=0, last<=1.
//    Also ack0/1=0, rdata0/1=0, ready=0. ram_en is gated by rst_n: no write in any cycle with rst_n low.
//  - States: CLEAR, IDLE, ACCESS (encoding in package).
//  - CLEAR: ram_en=1, ram_ab=clr_cnt, ram_dbi=CLR_VAL; clr_cnt++ each cycle.
//    After the word at 2**AW-1 -> IDLE. Lasts exactly 2**AW cycles. Requests are ignored (no ack).
//  - IDLE: ram_en=0, ram_ab=0. If any req: pick winner -> ACCESS with owner=winner. Else stay.
//  - Pick rule: single requester wins; if both, winner = !last (the one not served most recently).
//  - ACCESS: ram_ab=addr[owner], ram_dbi=wdata[owner], ram_en=we[owner]; ack[owner]=1 (decoded from state flops).
//    At the posedge: if !we[owner], rdata[owner]<=ram_dbo. last<=owner.
//    Next state: if req[!owner] -> ACCESS, owner=!owner; else IDLE.
//    The just-served requester is masked for this decision, since its req is still high in its ack cycle.
//  - Throughput: 1 access/cycle when both request (strict alternation); a lone requester gets 1 access per 2 cycles.
//  - Latency: req rising in cycle N with the arbiter idle -> ack in cycle N+1. Worst case under contention: N+2.
//  - Read data visible on rdata from the cycle after ack. Read-after-write to the same addr returns the new value.
//  - Same-cycle reads of one word by both requesters are impossible (one access per cycle).
//  - Requester changing addr/we/wdata before its ack: undefined (bench flags as protocol error).
//  - Reset mid-ACCESS: access abandoned, no ack, no write; clear sweep restarts at word 0.
//  - Address wrap: clr_cnt is AW+1 bits; terminal compare on clr_cnt == 2**AW-1; no wrap into word 0.
// STRUCTURE
//  - Package ram_arb_pkg: state enum {CLEAR, IDLE, ACCESS}, default AW/DW localparams.
//  - One sub-module rr_pick2: inputs req[1:0], last, mask_en, mask_idx; outputs valid, idx. Combinational.
//  - Top: state/owner/last/clr_cnt flops, output mux to ram, rdata registers.
// TESTING
//  1. Reset, hold rst_n=0 3 cycles, release: ready=0 for 16 cycles, ram_ab 0..15 with ram_en=1.
//     Then ready=1; a backdoor read of every word = CLR_VAL.
//  2. req0 write addr=5 wdata=A, then read addr=5: ack0 one cycle each, cycle after second ack rdata0=A.
//  3. Both req high from cycle N (req0 wr 3<-6, req1 rd 3): ack0 at N+1, ack1 at N+2, rdata1=6 at N+3.
//  4. Both hold req continuously for 8 accesses: acks alternate 0,1,0,1...; no idle cycle; no double ack.
//  5. Lone req1 reading addr 0..15 back-to-back (drop/raise req each ack): ack every other cycle, rdata1 matches model.
//  6. rst_n low during an ACCESS write to addr 9 of F: no ack, word 9 = CLR_VAL after sweep, rdata0/1=0.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and defaults for the ram access arbiter.
//   arb_state_e : arbiter FSM state (CLEAR sweep, IDLE, ACCESS)
//   ARB_AW      : default ram address width
//   ARB_DW      : default ram data width
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int ARB_AW = 4;
    localparam int ARB_DW = 4;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_access_arbiter_if
// Bundles the two requester ports and the ram pins seen by the arbiter.
//   req0/req1, we0/we1, addr0/1, wdata0/1 : requester -> arbiter
//   ack0/ack1, rdata0/1, ready            : arbiter -> requester
//   ram_en, ram_ab, ram_dbi               : arbiter -> ram
//   ram_dbo                               : ram -> arbiter (combinational read)
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds all of
// them stable until it sees ackN high at a clock edge; ackN is high for
// exactly the one cycle in which the access is presented to the ram. A
// requester may keep reqN high after the ack to ask for the next access.
// Modports: slave = arbiter side, master = requesters plus ram model.
// ----------------------------------------------------------------------------
interface ram_access_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          ready;
    logic          ram_en;
    logic [AW-1:0] ram_ab;
    logic [DW-1:0] ram_dbi;
    logic [DW-1:0] ram_dbo;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dbo,
        output ack0, ack1, rdata0, rdata1, ready, ram_en, ram_ab, ram_dbi
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dbo,
        input  ack0, ack1, rdata0, rdata1, ready, ram_en, ram_ab, ram_dbi
    );

endinterface

// File: rtl/ram_access_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   i_req[1:0]  : request vector
//   i_last      : index served most recently (loses a tie)
//   i_mask_en   : when 1, request i_mask_idx is ignored
//   i_mask_idx  : index to ignore
//   o_valid     : at least one unmasked request
//   o_idx       : winning index (meaningful only when o_valid)
// ----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_mask_en,
    input  logic       i_mask_idx,
    output logic       o_valid,
    output logic       o_idx
);

    logic [1:0] w_req_m;

    always_comb begin
        w_req_m = i_req;
        if (i_mask_en) begin
            w_req_m[i_mask_idx] = 1'b0;
        end
        o_valid = |w_req_m;
        // A tie goes to the requester that was not served last; otherwise
        // the single remaining request wins.
        o_idx   = (w_req_m == 2'b11) ? ~i_last : w_req_m[1];
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// ram_access_arbiter
// Shares a single-port ram (async read, sync write) between two requesters:
// requester 0 (button/edit path) and requester 1 (display-scan path). After
// reset it writes CLR_VAL to every word, then grants one access per cycle in
// round-robin order. It owns the ram enable, address and write-data pins.
// Ports:
//   clk          : clock, all state on posedge
//   rst_n        : synchronous active-low reset
//   bus          : requester handshake + ram pins (slave modport)
//   o_dbg_state  : current FSM state
// ----------------------------------------------------------------------------
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int            AW      = ARB_AW,
    parameter int            DW      = ARB_DW,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_arbiter_if.slave   bus,
    output arb_state_e            o_dbg_state
);

    // Last word of the clear sweep; the counter is one bit wider so the
    // terminal compare never aliases back onto word 0.
    localparam logic [AW:0] CLR_LAST = {1'b0, {AW{1'b1}}};

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic          r_last;
    logic [AW:0]   r_clr_cnt;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_pick_valid;
    logic          w_pick_idx;

    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          w_ram_en;
    logic [AW-1:0] w_ram_ab;
    logic [DW-1:0] w_ram_dbi;
    logic          w_ack0;
    logic          w_ack1;
    logic          w_ready;

    assign w_sel_we    = r_owner ? bus.we1    : bus.we0;
    assign w_sel_addr  = r_owner ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = r_owner ? bus.wdata1 : bus.wdata0;

    // During ACCESS the owner's req is still high in its ack cycle, so it is
    // masked out; otherwise a lone requester would be granted twice in a row.
    rr_pick2 u_pick (
        .i_req      ({bus.req1, bus.req0}),
        .i_last     (r_last),
        .i_mask_en  (r_state == ACCESS),
        .i_mask_idx (r_owner),
        .o_valid    (w_pick_valid),
        .o_idx      (w_pick_idx)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (r_state == ACCESS) begin
                r_last <= r_owner;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE, ACCESS: begin
                if (w_pick_valid) begin
                    w_state_nxt = ACCESS;
                    w_owner_nxt = w_pick_idx;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Everything is gated by rst_n so that a reset landing in an ACCESS
    // cycle abandons the access: no ack and no ram write.
    always_comb begin
        w_ram_en  = 1'b0;
        w_ram_ab  = '0;
        w_ram_dbi = '0;
        w_ack0    = 1'b0;
        w_ack1    = 1'b0;
        w_ready   = 1'b0;
        if (rst_n) begin
            case (r_state)
                CLEAR: begin
                    w_ram_en  = 1'b1;
                    w_ram_ab  = r_clr_cnt[AW-1:0];
                    w_ram_dbi = CLR_VAL;
                end
                IDLE: begin
                    w_ready = 1'b1;
                end
                ACCESS: begin
                    w_ready   = 1'b1;
                    w_ram_en  = w_sel_we;
                    w_ram_ab  = w_sel_addr;
                    w_ram_dbi = w_sel_wdata;
                    w_ack0    = ~r_owner;
                    w_ack1    = r_owner;
                end
                default: begin
                    w_ready = 1'b0;
                end
            endcase
        end
    end

    // ---------------- read data registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ACCESS && !w_sel_we) begin
            if (r_owner) begin
                r_rdata1 <= bus.ram_dbo;
            end else begin
                r_rdata0 <= bus.ram_dbo;
            end
        end
    end

    assign bus.ram_en   = w_ram_en;
    assign bus.ram_ab   = w_ram_ab;
    assign bus.ram_dbi  = w_ram_dbi;
    assign bus.ack0     = w_ack0;
    assign bus.ack1     = w_ack1;
    assign bus.ready    = w_ready;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_access_arbiter
// Bench for ram_access_arbiter with a 16x4 ram model (async read, sync
// write). Expected accesses are queued before stimulus; a negedge monitor
// pops one entry per ack and checks the ram pins and the read data that
// follows.
// ----------------------------------------------------------------------------
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_arbiter_if #(.AW(4), .DW(4)) bus ();
    arb_state_e dbg_state;

    ram_access_arbiter #(.AW(4), .DW(4), .CLR_VAL(4'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- ram model and cycle counter ----------------
    logic [3:0] mem [16];
    bit         prefill = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prefill) begin
            mem[cyc[3:0]] <= {cyc[2:0], 1'b1};
        end else if (bus.ram_en) begin
            mem[bus.ram_ab] <= bus.ram_dbi;
        end
    end
    assign bus.ram_dbo = mem[bus.ram_ab];

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];      // {port, we, addr, data}
    int         ack_cyc_q [$];
    logic [3:0] model_mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit p, input bit we, input logic [3:0] a, input logic [3:0] d);
        exp_q.push_back({p, we, a, d});
        if (we) begin
            model_mem[a] = d;
        end
    endtask

    initial begin : monitor
        logic [9:0] e;
        bit         pend;
        logic       pend_port;
        logic [3:0] pend_data;
        pend = 1'b0;
        pend_port = 1'b0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (pend_port) check("rdata1", 32'(bus.rdata1), 32'(pend_data));
                else           check("rdata0", 32'(bus.rdata0), 32'(pend_data));
                pend = 1'b0;
            end
            if (bus.ack0 || bus.ack1) begin
                ack_cyc_q.push_back(cyc);
                check("single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual ack0=%b ack1=%b expected none", bus.ack0, bus.ack1);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_port", 32'(bus.ack1), 32'(e[9]));
                    check("ram_en",   32'(bus.ram_en), 32'(e[8]));
                    check("ram_ab",   32'(bus.ram_ab), 32'(e[7:4]));
                    if (e[8]) begin
                        check("ram_dbi", 32'(bus.ram_dbi), 32'(e[3:0]));
                    end else begin
                        pend      = 1'b1;
                        pend_port = e[9];
                        pend_data = e[3:0];
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic drive(input bit p, input bit we, input logic [3:0] a,
                         input logic [3:0] d, input bit hold);
        bit got;
        got = 1'b0;
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (p ? bus.ack1 : bus.ack0) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout port=%0d actual no ack expected ack within 16 cycles", p);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (p) bus.req1 = 1'b0;
            else   bus.req0 = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int n;
        int bad;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;

        // 1. Reset with ram pre-filled, then the clear sweep.
        rst_n = 1'b0;
        prefill = 1'b1;
        repeat (16) @(posedge clk);
        #1 prefill = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready",  32'(bus.ready),  32'd0);
            check("rst_ram_en", 32'(bus.ram_en), 32'd0);
            check("rst_ack",    32'({bus.ack1, bus.ack0}), 32'd0);
            check("rst_rdata",  32'({bus.rdata1, bus.rdata0}), 32'd0);
        end
        check("rst_no_write", 32'(mem[2]), 32'h5);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("clr_ready",  32'(bus.ready),   32'd0);
            check("clr_ram_en", 32'(bus.ram_en),  32'd1);
            check("clr_ram_ab", 32'(bus.ram_ab),  32'(i));
            check("clr_dbi",    32'(bus.ram_dbi), 32'h0);
        end
        @(negedge clk);
        check("ready_after_clr", 32'(bus.ready), 32'd1);
        check("idle_after_clr",  32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < 16; i++) check("clr_word", 32'(mem[i]), 32'h0);
        @(posedge clk);
        #1;

        // 2. Write 5 <- A then read 5 on requester 0.
        push(0, 1, 4'd5, 4'hA);
        push(0, 0, 4'd5, 4'hA);
        drive(0, 1, 4'd5, 4'hA, 0);
        drive(0, 0, 4'd5, 4'h0, 0);
        idle_cycles(2);

        // Requester 1 reads 5 so that requester 1 becomes most recently served.
        push(1, 0, 4'd5, 4'hA);
        drive(1, 0, 4'd5, 4'h0, 0);
        idle_cycles(2);

        // 3. Contention: req0 writes 3 <- 6, req1 reads 3 in the same cycle.
        ack_cyc_q.delete();
        n = cyc;
        push(0, 1, 4'd3, 4'h6);
        push(1, 0, 4'd3, 4'h6);
        fork
            drive(0, 1, 4'd3, 4'h6, 0);
            drive(1, 0, 4'd3, 4'h0, 0);
        join
        check("t3_ack_count", 32'(ack_cyc_q.size()), 32'd2);
        check("t3_ack0_cycle", (ack_cyc_q.size() > 0) ? 32'(ack_cyc_q[0]) : 32'hFFFF_FFFF, 32'(n + 1));
        check("t3_ack1_cycle", (ack_cyc_q.size() > 1) ? 32'(ack_cyc_q[1]) : 32'hFFFF_FFFF, 32'(n + 2));
        idle_cycles(2);

        // 4. Both hold requests for 8 accesses: writes 8..11 interleaved with reads.
        ack_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 4'(8 + i), 4'(1 + i));
            push(1, 0, 4'(8 + i), 4'(1 + i));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) drive(0, 1, 4'(8 + i), 4'(1 + i), i < 3);
            end
            begin
                for (int j = 0; j < 4; j++) drive(1, 0, 4'(8 + j), 4'h0, j < 3);
            end
        join
        check("t4_ack_count", 32'(ack_cyc_q.size()), 32'd8);
        check("t4_no_gap", (ack_cyc_q.size() == 8) ? 32'(ack_cyc_q[7] - ack_cyc_q[0]) : 32'hFFFF_FFFF, 32'd7);
        idle_cycles(2);

        // 5. Lone requester 1 reads every word back to back.
        ack_cyc_q.delete();
        for (int a = 0; a < 16; a++) push(1, 0, 4'(a), model_mem[a]);
        for (int a = 0; a < 16; a++) drive(1, 0, 4'(a), 4'h0, a < 15);
        bad = 0;
        for (int i = 1; i < ack_cyc_q.size(); i++) begin
            if (ack_cyc_q[i] - ack_cyc_q[i-1] != 2) bad++;
        end
        check("t5_ack_count", 32'(ack_cyc_q.size()), 32'd16);
        check("t5_spacing_bad", 32'(bad), 32'd0);
        idle_cycles(2);

        // 6. Reset lands in the ACCESS cycle of a write 9 <- F.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd9; bus.wdata0 = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t6_in_access", 32'(dbg_state), 32'(ACCESS));
        check("t6_no_ack",    32'({bus.ack1, bus.ack0}), 32'd0);
        check("t6_no_write",  32'(bus.ram_en), 32'd0);
        @(posedge clk);
        #1 bus.req0 = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        check("t6_word9_kept", 32'(mem[9]), 32'h2);
        check("t6_rdata0", 32'(bus.rdata0), 32'h0);
        check("t6_rdata1", 32'(bus.rdata1), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (16) @(negedge clk);
        @(negedge clk);
        check("t6_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 16; i++) check("t6_clr_word", 32'(mem[i]), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
